ifetch: RTL and testbench
=========================

// Module: ifetch
// PURPOSE
//  Instruction fetch stage, directly upstream of the dispatcher. Holds the PC and issues
//  one outstanding request at a time to the icache. Predicts next PC (JAL, 2-bit BHT for
//  B-type) and buffers fetched instructions in a small FIFO. The FIFO head is presented
//  to the dispatcher, which consumes it in any cycle where full is low. Flushed on rollback.
// PARAMETERS
//  IQ_DEPTH_LOG    2   log2 of instruction-queue entries (4)
//  BHT_INDEX_BITS  8   BHT index width; 256 x 2-bit counters, index = pc[BHT_INDEX_BITS+1:2]
//  RESET_PC        0   PC loaded on reset
// PORTS
//  clk                           in   1   clock
//  rst                           in   1   synchronous active-high reset
//  rdy                           in   1   global ready; low freezes all state
//  rollback                      in   1   mispredict flush from ROB
//  rollback_pc                   in   32  redirect target
//  full                          in   1   ROB/RS/LSB cannot accept; dispatcher will not consume
//  req_valid_to_icache           out  1   fetch request (held until served)
//  req_addr_to_icache            out  32  fetch address
//  inst_valid_from_icache        in   1   response strobe (one cycle)
//  inst_from_icache              in   32  fetched word
//  valid_to_dispatcher           out  1   FIFO head valid
//  inst_to_dispatcher            out  32  head instruction
//  pc_to_dispatcher              out  32  head instruction's own PC
//  predicted_jump_to_dispatcher  out  1   head predicted taken
//  bht_update_valid              in   1   ROB commits a B-type
//  bht_update_pc                 in   32  its PC
//  bht_update_taken              in   1   actual outcome
// BEHAVIOUR
//  Reset: pc=RESET_PC, FIFO empty, state IDLE, req_valid_to_icache=0, req_addr=0,
//    all BHT counters=2'b01. Dispatcher outputs are 0 while FIFO is empty.
//  Precedence: rst > ~rdy (full freeze, no push/pop/update) > rollback > normal.
//  FSM IDLE: if FIFO count < 2^IQ_DEPTH_LOG -> req_valid<=1, req_addr<=pc, go WAIT.
//  FSM WAIT: hold req until inst_valid_from_icache, then:
//    - push {inst, pc, pred}, req_valid<=0, pc<=next_pc, go IDLE.
//    - Issue/room check happens only in IDLE. Pops during WAIT only free space,
//      so a push never overflows.
//  next_pc / pred, computed from inst_from_icache:
//    - opcode 1101111 (JAL): pc+immJ, pred=1.
//    - opcode 1100011 (B): if BHT[idx][1] then pc+immB, pred=1, else pc+4, pred=0.
//    - All others, including JALR: pc+4, pred=0.
//    - Immediates are sign-extended; additions are 32-bit modulo.
//  Dispatcher outputs are combinational from the FIFO head: valid = (count != 0).
//  Pop when valid && ~full && rdy && ~rollback. Push and pop may occur in the same
//    cycle; count is then unchanged. Pointers wrap modulo 2^IQ_DEPTH_LOG.
//  Rollback (single cycle):
//    - FIFO emptied (count=0); valid_to_dispatcher=0 on the next cycle.
//    - pc<=rollback_pc, req_valid<=0, state IDLE.
//    - An icache response arriving in the rollback cycle is discarded.
//    - Deasserting req_valid cancels the icache access (icache protocol).
//    - The new request issues on the following cycle.
//  BHT update: saturating 2-bit counter at bht_update_pc[BHT_INDEX_BITS+1:2]; +1 if
//    taken, -1 if not. Updates apply even during rollback. A same-cycle lookup of the
//    same index sees the old value.
// TESTING
//  1. Reset, rdy=1 -> cycle after reset req_valid=1, req_addr=0x0; valid_to_dispatcher=0.
//  2. Respond 0x0100006F (JAL +0x10) at pc 0 -> head inst=0x0100006F, pc=0, pred=1;
//     next req_addr=0x10.
//  3. full=1, icache answers every request with NOP 0x00000013 -> exactly 4 pushes,
//     req_valid stays 0, head stays pc=0x0; full=0 -> one pop per cycle, pcs 0,4,8,C.
//  4. Rollback with rollback_pc=0x200 while in WAIT and 3 entries queued -> next cycle
//     valid_to_dispatcher=0; following cycle req_addr=0x200.
//  5. Two bht_update taken at pc 0x20, then fetch BEQ +8 (0x00000463) at 0x20 -> pred=1,
//     next req 0x28. Without training -> pred=0, next req 0x24.
//  6. rdy=0 for 3 cycles with response strobe and full=0 -> no push/pop, outputs stable.

Source files
------------

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, one-outstanding icache request FSM,
// JAL / 2-bit-BHT branch prediction and a small instruction queue for the dispatcher.
module ifetch #(
   parameter int          IQ_DEPTH_LOG   = 2,
   parameter int          BHT_INDEX_BITS = 8,
   parameter logic [31:0] RESET_PC       = 32'h0
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        rollback,
   input  logic [31:0] rollback_pc,
   input  logic        full,
   output logic        req_valid_to_icache,
   output logic [31:0] req_addr_to_icache,
   input  logic        inst_valid_from_icache,
   input  logic [31:0] inst_from_icache,
   output logic        valid_to_dispatcher,
   output logic [31:0] inst_to_dispatcher,
   output logic [31:0] pc_to_dispatcher,
   output logic        predicted_jump_to_dispatcher,
   input  logic        bht_update_valid,
   input  logic [31:0] bht_update_pc,
   input  logic        bht_update_taken
);

   localparam int IQ_DEPTH = 1 << IQ_DEPTH_LOG;
   localparam int BHT_SIZE = 1 << BHT_INDEX_BITS;
   localparam logic [IQ_DEPTH_LOG:0] IQ_FULL = (IQ_DEPTH_LOG + 1)'(IQ_DEPTH);
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   state_t state, state_next;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        pred;
   logic        issue;
   logic        push;
   logic        pop;

   logic [31:0]             inst_q [IQ_DEPTH];
   logic [31:0]             pc_q   [IQ_DEPTH];
   logic                    pred_q [IQ_DEPTH];
   logic [IQ_DEPTH_LOG-1:0] head, tail;
   logic [IQ_DEPTH_LOG:0]   count;

   logic [1:0]                bht [BHT_SIZE];
   logic [BHT_INDEX_BITS-1:0] lookup_idx, update_idx;
   logic [31:0]               imm_j, imm_b;
   logic                      unused_update_bits;

   assign lookup_idx = pc[BHT_INDEX_BITS+1:2];
   assign update_idx = bht_update_pc[BHT_INDEX_BITS+1:2];
   assign unused_update_bits = &{1'b0, bht_update_pc[31:BHT_INDEX_BITS+2], bht_update_pc[1:0]};

   always_comb begin
      imm_j   = {{12{inst_from_icache[31]}}, inst_from_icache[19:12], inst_from_icache[20],
                 inst_from_icache[30:21], 1'b0};
      imm_b   = {{20{inst_from_icache[31]}}, inst_from_icache[7], inst_from_icache[30:25],
                 inst_from_icache[11:8], 1'b0};
      next_pc = pc + 32'd4;
      pred    = 1'b0;
      if (inst_from_icache[6:0] == OP_JAL) begin
         next_pc = pc + imm_j;
         pred    = 1'b1;
      end else if (inst_from_icache[6:0] == OP_BRANCH && bht[lookup_idx][1]) begin
         next_pc = pc + imm_b;
         pred    = 1'b1;
      end
   end

   // Rollback overrides both issuing and pushing, discarding any same-cycle response.
   always_comb begin
      state_next = state;
      issue      = 1'b0;
      push       = 1'b0;
      case (state)
         S_IDLE: if (count < IQ_FULL) begin
            issue      = 1'b1;
            state_next = S_WAIT;
         end
         S_WAIT: if (inst_valid_from_icache) begin
            push       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
      if (rollback) begin
         issue      = 1'b0;
         push       = 1'b0;
         state_next = S_IDLE;
      end
   end

   assign valid_to_dispatcher          = (count != '0);
   assign pop                          = valid_to_dispatcher && !full && rdy && !rollback;
   assign inst_to_dispatcher           = valid_to_dispatcher ? inst_q[head] : 32'h0;
   assign pc_to_dispatcher             = valid_to_dispatcher ? pc_q[head]   : 32'h0;
   assign predicted_jump_to_dispatcher = valid_to_dispatcher ? pred_q[head] : 1'b0;

   always_ff @(posedge clk) begin
      if (rst)      state <= S_IDLE;
      else if (rdy) state <= state_next;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc                  <= RESET_PC;
         req_valid_to_icache <= 1'b0;
         req_addr_to_icache  <= 32'h0;
         head                <= '0;
         tail                <= '0;
         count               <= '0;
      end else if (rdy) begin
         if (rollback) begin
            pc                  <= rollback_pc;
            req_valid_to_icache <= 1'b0;
            head                <= '0;
            tail                <= '0;
            count               <= '0;
         end else begin
            if (issue) begin
               req_valid_to_icache <= 1'b1;
               req_addr_to_icache  <= pc;
            end
            if (push) begin
               req_valid_to_icache <= 1'b0;
               pc                  <= next_pc;
               tail                <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && rdy && push) begin
         inst_q[tail] <= inst_from_icache;
         pc_q[tail]   <= pc;
         pred_q[tail] <= pred;
      end
   end

   // Counter updates land even in a rollback cycle; lookups in that cycle see the old value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < BHT_SIZE; i++) bht[i] <= 2'b01;
      end else if (rdy && bht_update_valid) begin
         if (bht_update_taken && bht[update_idx] != 2'b11)
            bht[update_idx] <= bht[update_idx] + 2'b01;
         else if (!bht_update_taken && bht[update_idx] != 2'b00)
            bht[update_idx] <= bht[update_idx] - 2'b01;
      end
   end

endmodule

// File: tb/tb_ifetch.sv
// Directed bench for ifetch: drives the icache/ROB side by hand at negedges and
// compares outputs against hand-computed values.
module tb_ifetch;

   localparam logic [31:0] NOP      = 32'h00000013;
   localparam logic [31:0] JAL_P16  = 32'h0100006F;
   localparam logic [31:0] JAL_M16  = 32'hFF1FF06F;
   localparam logic [31:0] BEQ_P8   = 32'h00000463;
   localparam logic [31:0] JALR_RA  = 32'h000080E7;

   logic        clk = 1'b0;
   logic        rst, rdy, rollback, full;
   logic [31:0] rollback_pc;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        inst_valid;
   logic [31:0] inst;
   logic        valid;
   logic [31:0] head_inst, head_pc;
   logic        head_pred;
   logic        bht_update_valid, bht_update_taken;
   logic [31:0] bht_update_pc;

   int vecCount  = 0;
   int missCount = 0;

   always #5 clk = ~clk;

   ifetch dut (
      .clk                          (clk),
      .rst                          (rst),
      .rdy                          (rdy),
      .rollback                     (rollback),
      .rollback_pc                  (rollback_pc),
      .full                         (full),
      .req_valid_to_icache          (req_valid),
      .req_addr_to_icache           (req_addr),
      .inst_valid_from_icache       (inst_valid),
      .inst_from_icache             (inst),
      .valid_to_dispatcher          (valid),
      .inst_to_dispatcher           (head_inst),
      .pc_to_dispatcher             (head_pc),
      .predicted_jump_to_dispatcher (head_pred),
      .bht_update_valid             (bht_update_valid),
      .bht_update_pc                (bht_update_pc),
      .bht_update_taken             (bht_update_taken)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vecCount++;
      if (observed !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic applyReset();
      rst = 1'b1; rdy = 1'b1; rollback = 1'b0; rollback_pc = 32'h0; full = 1'b1;
      inst_valid = 1'b0; inst = 32'h0;
      bht_update_valid = 1'b0; bht_update_pc = 32'h0; bht_update_taken = 1'b0;
      tick(2);
      checkOutput("rstReqValid", 32'(req_valid), 32'h0);
      checkOutput("rstValid", 32'(valid), 32'h0);
      checkOutput("rstHeadInst", head_inst, 32'h0);
      rst = 1'b0;
   endtask

   // Wait (bounded) for an outstanding request, then answer it with a one-cycle strobe.
   task automatic serveOne(input logic [31:0] word);
      int waited = 0;
      while (!req_valid && waited < 20) begin
         tick(1);
         waited++;
      end
      checkOutput("reqSeen", 32'(req_valid), 32'h1);
      if (req_valid) begin
         inst = word;
         inst_valid = 1'b1;
         tick(1);
         inst_valid = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // First request and JAL prediction
      applyReset();
      tick(1);
      checkOutput("firstReqValid", 32'(req_valid), 32'h1);
      checkOutput("firstReqAddr", req_addr, 32'h0);
      checkOutput("firstValid", 32'(valid), 32'h0);
      serveOne(JAL_P16);
      checkOutput("jalHeadValid", 32'(valid), 32'h1);
      checkOutput("jalHeadInst", head_inst, JAL_P16);
      checkOutput("jalHeadPc", head_pc, 32'h0);
      checkOutput("jalHeadPred", 32'(head_pred), 32'h1);
      checkOutput("jalReqDropped", 32'(req_valid), 32'h0);
      tick(1);
      checkOutput("jalNextAddr", req_addr, 32'h10);
      serveOne(JAL_M16);
      tick(1);
      checkOutput("jalBackAddr", req_addr, 32'h0);
      checkOutput("jalBackHeadPc", head_pc, 32'h0);

      // Fill the queue while full, then drain one per cycle
      applyReset();
      for (int k = 0; k < 4; k++) serveOne(NOP);
      tick(4);
      checkOutput("fillNoReq", 32'(req_valid), 32'h0);
      checkOutput("fillHeadPc", head_pc, 32'h0);
      full = 1'b0;
      checkOutput("drainPc0", head_pc, 32'h0);
      for (int k = 1; k < 4; k++) begin
         tick(1);
         checkOutput($sformatf("drainPc%0d", k), head_pc, 32'(4 * k));
      end
      tick(1);
      checkOutput("drainEmpty", 32'(valid), 32'h0);
      checkOutput("drainReqAddr", req_addr, 32'h10);
      checkOutput("drainReqValid", 32'(req_valid), 32'h1);

      // Rollback while waiting, with a response in the same cycle
      applyReset();
      for (int k = 0; k < 3; k++) serveOne(NOP);
      tick(1);
      checkOutput("rbPreAddr", req_addr, 32'hC);
      rollback = 1'b1; rollback_pc = 32'h200; inst = NOP; inst_valid = 1'b1;
      tick(1);
      rollback = 1'b0; inst_valid = 1'b0;
      checkOutput("rbEmpty", 32'(valid), 32'h0);
      checkOutput("rbReqDropped", 32'(req_valid), 32'h0);
      tick(1);
      checkOutput("rbReqValid", 32'(req_valid), 32'h1);
      checkOutput("rbReqAddr", req_addr, 32'h200);
      serveOne(NOP);
      checkOutput("rbHeadPc", head_pc, 32'h200);

      // Trained branch predicted taken (updates overlap the rollback cycle)
      applyReset();
      tick(1);
      rollback = 1'b1; rollback_pc = 32'h20;
      bht_update_valid = 1'b1; bht_update_pc = 32'h20; bht_update_taken = 1'b1;
      tick(1);
      rollback = 1'b0;
      tick(1);
      bht_update_valid = 1'b0;
      serveOne(BEQ_P8);
      checkOutput("bhtTakenPc", head_pc, 32'h20);
      checkOutput("bhtTakenPred", 32'(head_pred), 32'h1);
      tick(1);
      checkOutput("bhtTakenNext", req_addr, 32'h28);

      // Untrained branch predicted not taken
      applyReset();
      tick(1);
      rollback = 1'b1; rollback_pc = 32'h20;
      tick(1);
      rollback = 1'b0;
      serveOne(BEQ_P8);
      checkOutput("bhtColdPred", 32'(head_pred), 32'h0);
      tick(1);
      checkOutput("bhtColdNext", req_addr, 32'h24);

      // Counter saturates at 0: three not-taken then one taken stays weakly not-taken
      applyReset();
      tick(1);
      rollback = 1'b1; rollback_pc = 32'h20;
      bht_update_valid = 1'b1; bht_update_pc = 32'h20; bht_update_taken = 1'b0;
      tick(1);
      rollback = 1'b0;
      tick(2);
      bht_update_taken = 1'b1;
      tick(1);
      bht_update_valid = 1'b0;
      serveOne(BEQ_P8);
      checkOutput("bhtSatPred", 32'(head_pred), 32'h0);
      tick(1);
      checkOutput("bhtSatNext", req_addr, 32'h24);

      // rdy low freezes everything despite strobe and full low
      applyReset();
      serveOne(NOP);
      tick(1);
      checkOutput("frzPreAddr", req_addr, 32'h4);
      rdy = 1'b0; inst = NOP; inst_valid = 1'b1; full = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick(1);
         checkOutput("frzValid", 32'(valid), 32'h1);
         checkOutput("frzHeadPc", head_pc, 32'h0);
         checkOutput("frzReqValid", 32'(req_valid), 32'h1);
         checkOutput("frzReqAddr", req_addr, 32'h4);
      end
      rdy = 1'b1; inst_valid = 1'b0; full = 1'b1;
      serveOne(JALR_RA);
      checkOutput("frzAfterHeadPc", head_pc, 32'h0);
      tick(1);
      checkOutput("jalrNextAddr", req_addr, 32'h8);
      full = 1'b0;
      checkOutput("frzDrain0Inst", head_inst, NOP);
      tick(1);
      checkOutput("jalrHeadPc", head_pc, 32'h4);
      checkOutput("jalrHeadInst", head_inst, JALR_RA);
      checkOutput("jalrHeadPred", 32'(head_pred), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
